// File: rtl/pito_pkg.sv
// pito_pkg: shared types and constants for the pito UART transmit path
package pito_pkg;
  localparam int PITO_NUM_HARTS = 8;
  localparam logic [31:0] PITO_UART_TX_ADDR = 32'h8000_0000;
  localparam logic [7:0] PITO_UART_EOL = 8'h0A;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} uart_arb_state_e;
  typedef logic [$clog2(PITO_NUM_HARTS)-1:0] pito_hart_id_t;
endpackage

// File: rtl/pito_uart_hart_fifo.sv
// pito_uart_hart_fifo: single-clock DEPTH x 8 byte FIFO for one hart
// Ports: i_push/i_data write (ignored when full), i_pop read (ignored when empty),
//        o_data shows the head byte, o_full/o_empty status.
module pito_uart_hart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_wr, w_rd;
  // The extra top pointer bit tells a full FIFO apart from an empty one.
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_data  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + (AW+1)'(w_wr);
      r_rp <= r_rp + (AW+1)'(w_rd);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
endmodule

// File: rtl/pito_uart_tx_arbiter.sv
// pito_uart_tx_arbiter: round-robin sharing of one pito_uart transmitter among the harts
// Ports: wr_valid/wr_hart/wr_data/wr_ready hart store capture; uart_busy/uart_wr/uart_tx_data
//        UART handshake; fifo_full, overflow/overflow_clr status; active_valid/active_hart in-flight byte.
// Option: PITO_UART_ARB_LINE_EN keeps a hart granted until it sends a newline.
module pito_uart_tx_arbiter
  import pito_pkg::*;
#(
  parameter int NUM_HARTS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [$clog2(NUM_HARTS)-1:0] wr_hart,
  input  logic [7:0]                   wr_data,
  output logic                         wr_ready,
  input  logic                         uart_busy,
  output logic                         uart_wr,
  output logic [7:0]                   uart_tx_data,
  output logic [NUM_HARTS-1:0]         fifo_full,
  output logic [NUM_HARTS-1:0]         overflow,
  input  logic [NUM_HARTS-1:0]         overflow_clr,
  output logic                         active_valid,
  output logic [$clog2(NUM_HARTS)-1:0] active_hart
);
  localparam int HW = $clog2(NUM_HARTS);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  uart_arb_state_e r_state;
  logic [HW-1:0] r_rr, r_active_hart, w_sel, w_gnt_hart;
  logic [TW-1:0] r_to;
  logic [NUM_HARTS-1:0] w_full, w_empty, w_push, w_pop, r_ovf;
  logic [7:0] w_head [NUM_HARTS];
  logic [7:0] r_tx;
  logic r_wr, r_active, w_any, w_grant;
  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_fifo
    assign w_push[g] = wr_valid && wr_hart == HW'(g);
    pito_uart_hart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .i_push(w_push[g]), .i_data(wr_data), .i_pop(w_pop[g]),
      .o_data(w_head[g]), .o_full(w_full[g]), .o_empty(w_empty[g]));
  end
  // Scanning from the far end down lets the hart nearest after the RR pointer win.
  always_comb begin
    int j;
    j = 0;
    w_sel = r_rr;
    w_any = 1'b0;
    for (int i = NUM_HARTS; i >= 1; i--) begin
      j = (int'(r_rr) + i) % NUM_HARTS;
      if (!w_empty[HW'(j)]) begin
        w_sel = HW'(j);
        w_any = 1'b1;
      end
    end
  end
`ifdef PITO_UART_ARB_LINE_EN
  logic r_lock;
  logic [4:0] r_lock_cnt;
  assign w_grant    = !uart_busy && (r_lock ? !w_empty[r_active_hart] : w_any);
  assign w_gnt_hart = r_lock ? r_active_hart : w_sel;
`else
  assign w_grant    = !uart_busy && w_any;
  assign w_gnt_hart = w_sel;
`endif
  assign w_pop        = (r_state == IDLE && w_grant) ? NUM_HARTS'(1) << w_gnt_hart : '0;
  assign wr_ready     = !w_full[wr_hart];
  assign fifo_full    = w_full;
  assign overflow     = r_ovf;
  assign uart_wr      = r_wr;
  assign uart_tx_data = r_tx;
  assign active_valid = r_active;
  assign active_hart  = r_active_hart;
  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ovf <= '0;
    else r_ovf <= (r_ovf & ~overflow_clr) | ((wr_valid && !wr_ready) ? NUM_HARTS'(1) << wr_hart : '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_rr          <= HW'(NUM_HARTS - 1);
      r_active_hart <= '0;
      r_active      <= 1'b0;
      r_wr          <= 1'b0;
      r_tx          <= '0;
      r_to          <= '0;
`ifdef PITO_UART_ARB_LINE_EN
      r_lock        <= 1'b0;
      r_lock_cnt    <= '0;
`endif
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_tx          <= w_head[w_gnt_hart];
            r_active_hart <= w_gnt_hart;
            r_active      <= 1'b1;
            r_wr          <= 1'b1;
            r_state       <= ISSUE;
`ifdef PITO_UART_ARB_LINE_EN
            if (!r_lock) r_rr <= w_gnt_hart;
            r_lock     <= w_head[w_gnt_hart] != PITO_UART_EOL;
            r_lock_cnt <= '0;
          end else if (r_lock && w_empty[r_active_hart]) begin
            // An owner that goes quiet mid-line gives up the UART after 16 idle cycles.
            r_lock_cnt <= r_lock_cnt + 5'd1;
            if (r_lock_cnt == 5'd15) r_lock <= 1'b0;
`else
            r_rr <= w_gnt_hart;
`endif
          end
        end
        ISSUE: begin
          r_state <= WAIT_BUSY;
          r_to    <= '0;
        end
        WAIT_BUSY:
          if (uart_busy) r_state <= WAIT_DONE;
          else if (r_to == TW'(BUSY_TIMEOUT - 1)) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end else r_to <= r_to + 1'b1;
        WAIT_DONE:
          if (!uart_busy) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pito_uart_tx_arbiter.sv
// tb_pito_uart_tx_arbiter: directed self-checking bench for pito_uart_tx_arbiter
module tb_pito_uart_tx_arbiter;
  logic clk = 0, rst = 1;
  logic wr_valid = 0, wr_ready, uart_busy = 0, uart_wr, active_valid;
  logic [2:0] wr_hart = 0, active_hart;
  logic [7:0] wr_data = 0, uart_tx_data, fifo_full, overflow, overflow_clr = 0;
  int checks = 0, failures = 0, bad_wr = 0, busy_mode = 0, bcnt = 0;
  logic [7:0] tx_q[$];
  logic [2:0] hq[$];
  always #5 clk = ~clk;
  pito_uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_hart(wr_hart), .wr_data(wr_data),
    .wr_ready(wr_ready), .uart_busy(uart_busy), .uart_wr(uart_wr), .uart_tx_data(uart_tx_data),
    .fifo_full(fifo_full), .overflow(overflow), .overflow_clr(overflow_clr),
    .active_valid(active_valid), .active_hart(active_hart));
  // UART model: 0 = busy for 3 cycles after each wr, 1 = never busy, 2 = held busy
  always @(posedge clk)
    if (busy_mode == 2) uart_busy <= 1'b1;
    else if (busy_mode == 1) uart_busy <= 1'b0;
    else if (uart_wr) begin
      uart_busy <= 1'b1;
      bcnt <= 3;
    end else if (bcnt > 0) begin
      uart_busy <= bcnt > 1;
      bcnt <= bcnt - 1;
    end else uart_busy <= 1'b0;
  always @(negedge clk)
    if (!rst && uart_wr) begin
      tx_q.push_back(uart_tx_data);
      hq.push_back(active_hart);
      if (uart_busy) bad_wr++;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic push(input int h, input logic [7:0] d);
    wr_valid = 1;
    wr_hart = 3'(h);
    wr_data = d;
    tick();
    wr_valid = 0;
  endtask
  task automatic wait_wr(input string tag);
    int k = 0;
    while (!uart_wr && k < 40) begin
      tick();
      k++;
    end
    chk(tag, 32'(uart_wr), 1);
  endtask
  task automatic drain(input string tag, input int n);
    int k = 0;
    while ((tx_q.size() < n || active_valid) && k < 600) begin
      tick();
      k++;
    end
    chk(tag, tx_q.size(), n);
  endtask
  task automatic chk_seq(input string tag, input logic [7:0] exp[]);
    for (int i = 0; i < exp.size(); i++) chk(tag, (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF, 32'(exp[i]));
  endtask
  initial begin
    int n;
    @(negedge clk);
    chk("rst_uart_wr", 32'(uart_wr), 0);
    chk("rst_tx_data", 32'(uart_tx_data), 0);
    chk("rst_fifo_full", 32'(fifo_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_active_valid", 32'(active_valid), 0);
    chk("rst_active_hart", 32'(active_hart), 0);
    rst = 0;
    tick();
    // single byte latency
    push(3, 8'h41);
    chk("lat_no_early_wr", 32'(uart_wr), 0);
    tick();
    chk("lat_wr", 32'(uart_wr), 1);
    chk("lat_data", 32'(uart_tx_data), 32'h41);
    chk("lat_hart", 32'(active_hart), 3);
    chk("lat_active", 32'(active_valid), 1);
    drain("lat_drain", 1);
    chk("lat_busy_low_at_done", 32'(uart_busy), 0);
    // round robin among harts 0..2
    tx_q.delete();
    hq.delete();
    push(0, 8'hA0); push(1, 8'hB0); push(2, 8'hC0);
    push(0, 8'hA1); push(1, 8'hB1); push(2, 8'hC1);
    drain("rr_drain", 6);
`ifdef PITO_UART_ARB_LINE_EN
    chk_seq("rr_order", '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1});
`else
    chk_seq("rr_order", '{8'hA0, 8'hB0, 8'hC0, 8'hA1, 8'hB1, 8'hC1});
`endif
    chk("rr_no_wr_while_busy", bad_wr, 0);
    // overflow on hart 5 while the UART is held busy
    tx_q.delete();
    busy_mode = 2;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1;
      wr_hart = 3'd5;
      wr_data = 8'(8'h50 + i);
      #1 chk("ovf_wr_ready", 32'(wr_ready), (i < 4) ? 1 : 0);
      tick();
    end
    wr_valid = 0;
    chk("ovf_full", 32'(fifo_full), 32'h20);
    chk("ovf_flag", 32'(overflow), 32'h20);
    overflow_clr = 8'h20;
    tick();
    overflow_clr = 0;
    chk("ovf_clear", 32'(overflow), 0);
    overflow_clr = 8'h20;
    wr_valid = 1;
    wr_data = 8'h99;
    tick();
    overflow_clr = 0;
    wr_valid = 0;
    chk("ovf_set_wins", 32'(overflow), 32'h20);
    overflow_clr = 8'h20;
    tick();
    overflow_clr = 0;
    chk("ovf_no_tx_while_busy", tx_q.size(), 0);
    busy_mode = 0;
    drain("ovf_drain", 4);
    chk_seq("ovf_order", '{8'h50, 8'h51, 8'h52, 8'h53});
    // busy never rises: each byte ends by timeout
    busy_mode = 1;
    tick();
    tx_q.delete();
    push(6, 8'h61);
    wait_wr("to_wr");
    n = 0;
    while (active_valid && n < 20) begin
      n++;
      tick();
    end
    chk("to_active_cycles", n, 5);
    tx_q.delete();
    push(7, 8'h71); push(0, 8'h01);
    drain("to_drain", 2);
    chk_seq("to_order", '{8'h71, 8'h01});
    // reset during WAIT_DONE with busy held high
    busy_mode = 0;
    tick();
    push(1, 8'h33);
    wait_wr("rm_wr");
    busy_mode = 2;
    tick(); tick();
    push(2, 8'h44);
    chk("rm_in_flight", 32'(active_valid), 1);
    #2 rst = 1;
    #1;
    chk("rm_active_valid", 32'(active_valid), 0);
    chk("rm_uart_wr", 32'(uart_wr), 0);
    chk("rm_tx_data", 32'(uart_tx_data), 0);
    chk("rm_fifo_full", 32'(fifo_full), 0);
    chk("rm_active_hart", 32'(active_hart), 0);
    @(negedge clk);
    rst = 0;
    tx_q.delete();
    hq.delete();
    push(2, 8'h44);
    repeat (6) tick();
    chk("rm_wait_busy", tx_q.size(), 0);
    chk("rm_idle", 32'(active_valid), 0);
    busy_mode = 0;
    drain("rm_drain", 1);
    chk("rm_data", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF, 32'h44);
    chk("rm_hart", (hq.size() > 0) ? 32'(hq[0]) : 32'hFFFF, 2);
    // interleaved lines from harts 2 and 4
    rst = 1;
    tick();
    rst = 0;
    tx_q.delete();
    push(2, 8'h61); push(4, 8'h63); push(2, 8'h62);
    push(4, 8'h64); push(2, 8'h0A); push(4, 8'h0A);
    drain("line_drain", 6);
`ifdef PITO_UART_ARB_LINE_EN
    chk_seq("line_order", '{8'h61, 8'h62, 8'h0A, 8'h63, 8'h64, 8'h0A});
`else
    chk_seq("line_order", '{8'h61, 8'h63, 8'h62, 8'h64, 8'h0A, 8'h0A});
`endif
    chk("final_no_wr_while_busy", bad_wr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
